tomasulo_cdb_arb: RTL

// Common Data Bus (CDB) arbiter and broadcaster; the bus-owner end of the cdb_req/cdb_gnt handshake used by reservation stations.

---
 rtl/tomasulo_cdb_arb_if.sv | 27 ++
 rtl/tomasulo_cdb_arb.sv | 95 +++++++++
 2 files changed

// File: rtl/tomasulo_cdb_arb_if.sv
// Common Data Bus handshake bundle between result producers and the CDB arbiter.
// The master side is the arbiter, which owns the bus. The slave side is a producer.
interface tomasulo_cdb_arb_if #(
  parameter int N      = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic [N-1:0]        cdb_req;
  logic [N*TAG_W-1:0]  req_tag;
  logic [N*DATA_W-1:0] req_data;
  logic                cdb_stall;
  logic [N-1:0]        cdb_gnt;
  logic                cdb_vld_r;
  logic [TAG_W-1:0]    cdb_tag_r;
  logic [DATA_W-1:0]   cdb_data_r;
  logic [15:0]         bcast_cnt_r;

  modport master (
    input  cdb_req, req_tag, req_data, cdb_stall,
    output cdb_gnt, cdb_vld_r, cdb_tag_r, cdb_data_r, bcast_cnt_r
  );

  modport slave (
    output cdb_req, req_tag, req_data, cdb_stall,
    input  cdb_gnt, cdb_vld_r, cdb_tag_r, cdb_data_r, bcast_cnt_r
  );
endinterface

// File: rtl/tomasulo_cdb_arb.sv
// CDB arbiter and broadcaster. It grants at most one producer per cycle, using
// round-robin order with a starvation override. It then registers the winner's
// tag and data onto the broadcast bus on the following cycle.
module tomasulo_cdb_arb #(
  parameter int N          = 4,
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  tomasulo_cdb_arb_if.master bus
);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);

  logic [IDX_W-1:0]  ptr_r;
  logic [WAIT_W-1:0] wait_r [N];

  logic              gnt_any;
  logic [IDX_W-1:0]  gnt_idx;
  logic [N-1:0]      gnt;

  // Winner selection: a saturated waiter wins over round-robin order (lowest index first).
  always_comb begin
    logic starve_hit;
    int   j;
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    starve_hit = 1'b0;
    j          = 0;
    if (!bus.cdb_stall) begin
      // Scan downward so the last hit seen is the lowest index.
      for (int i = N - 1; i >= 0; i--) begin
        if (bus.cdb_req[i] && wait_r[i] == WAIT_W'(STARVE_MAX)) begin
          starve_hit = 1'b1;
          gnt_any    = 1'b1;
          gnt_idx    = IDX_W'(i);
        end
      end
      if (!starve_hit) begin
        // Scan downward so the last hit seen is the nearest one at or after ptr_r.
        for (int k = N - 1; k >= 0; k--) begin
          j = (int'(ptr_r) + k) % N;
          if (bus.cdb_req[j]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(j);
          end
        end
      end
    end
  end

  assign gnt         = gnt_any ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign bus.cdb_gnt = gnt;

  // Arbitration state: the rotate pointer follows the winner, and the wait counters track unserved requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
      for (int i = 0; i < N; i++) wait_r[i] <= '0;
    end else begin
      if (gnt_any)
        ptr_r <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      // Counters keep advancing under stall, so a long stall can push waiters into the override.
      for (int i = 0; i < N; i++) begin
        if (bus.cdb_req[i] && !gnt[i])
          wait_r[i] <= (wait_r[i] == WAIT_W'(STARVE_MAX)) ? wait_r[i] : wait_r[i] + 1'b1;
        else
          wait_r[i] <= '0;
      end
    end
  end

  // Broadcast register: the payload is captured in the grant cycle and held while the bus is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cdb_vld_r   <= 1'b0;
      bus.cdb_tag_r   <= '0;
      bus.cdb_data_r  <= '0;
      bus.bcast_cnt_r <= '0;
    end else begin
      bus.cdb_vld_r <= gnt_any;
      if (gnt_any) begin
        bus.cdb_tag_r   <= bus.req_tag[gnt_idx*TAG_W +: TAG_W];
        bus.cdb_data_r  <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
        bus.bcast_cnt_r <= bus.bcast_cnt_r + 16'd1;
      end
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(bus.cdb_gnt));
  a_gnt_subset : assert property (@(posedge clk) disable iff (rst) (bus.cdb_gnt & ~bus.cdb_req) == '0);
  a_gnt_stall  : assert property (@(posedge clk) disable iff (rst) !(bus.cdb_stall && |bus.cdb_gnt));
endmodule
